gol_board_scanner: RTL and testbench
====================================

Name: gol_board_scanner

Overview:
- Drives the neighbour side of the Game-of-Life cell interface. It owns a WIDTH x HEIGHT toroidal board and scans it one cell per clock.
- For each cell it presents the 8-bit neighbour vector and the cell's current state, and computes that cell's next state.
- At the end of a scan it commits the next-generation board and pulses done.
- It sits above the per-cell logic as the board/sequencer: host loads rows, requests steps and reads the board.

Parameters:
WIDTH, 8, columns per row (>=3)
HEIGHT, 8, number of rows (>=3)
GEN_W, 16, generation counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_en  in  1  write load_data into row load_row (IDLE only)
load_row  in  $clog2(HEIGHT)  row index for load
load_data  in  WIDTH  row contents, bit i = column i
step  in  1  request one generation (IDLE only)
busy  out  1  high in SCAN and COMMIT
done  out  1  one-cycle pulse in COMMIT
neigh_valid  out  1  high in SCAN; neigh_out/cell_state/cell_x/cell_y valid
neigh_out  out  8  neighbour vector of the cell being scanned
cell_state  out  1  current state of the cell being scanned
cell_x  out  $clog2(WIDTH)  scanned column
cell_y  out  $clog2(HEIGHT)  scanned row
board_out  out  WIDTH*HEIGHT  committed board, bit y*WIDTH+x
generation  out  GEN_W  number of completed generations

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; board and shadow board all 0; generation=0; busy=0; done=0; neigh_valid=0; neigh_out=0; cell_state=0; cell_x=0; cell_y=0.
- Neighbour bit order: 0=N(y-1), 1=NE, 2=E(x+1), 3=SE, 4=S(y+1), 5=SW, 6=W(x-1), 7=NW. Bit is 1 if that neighbour is alive.
- Coordinates wrap toroidally: x-1 at x=0 -> WIDTH-1; x+1 at WIDTH-1 -> 0; same for y.
- Next-state rule: next = (count==3) | (alive & count==2), where count = popcount(neigh_out), 0..8 in 4 bits.
- FSM IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE:
  - load_en=1: row load_row of the board takes load_data at the next edge.
  - load_row >= HEIGHT: the load is ignored.
  - step=1 with load_en=0: go to SCAN with x=y=0.
  - load_en and step in the same cycle: load wins, step is dropped.
- SCAN:
  - One cell per cycle, row-major: x increments; at WIDTH-1, x goes to 0 and y increments.
  - Outputs are combinational from the committed board and the x/y counters.
  - The next state is written into the shadow board at the edge.
  - After cell (WIDTH-1, HEIGHT-1): go to COMMIT.
  - SCAN lasts exactly WIDTH*HEIGHT cycles.
  - Reads always use the committed board, never the shadow.
- COMMIT (1 cycle): done=1, busy=1. At the edge, board <= shadow and generation increments (wraps modulo 2^GEN_W); return to IDLE.
- Latency: step sampled at edge E0 gives done high in cycle W*H+1 after E0. board_out shows the new generation in the cycle after done.
- step or load_en while busy: ignored, with no queueing.
- Reset mid-SCAN or mid-COMMIT: aborts immediately; the board is cleared, not preserved.

Decomposition:
- Package gol_pkg holds:
  - neighbour bit index constants (NB_N..NB_NW);
  - state enum {IDLE, SCAN, COMMIT};
  - a function gol_next(alive, neigh[7:0]).
- One sub-module: gol_neighbour_mux, combinational. It takes board, x, y and returns neigh[7:0] and alive, with wrap handling.

Test Plan:
- Blinker: load row3=8'b0001_1100, other rows 0; step.
  - done exactly 65 cycles after the step edge.
  - Then rows 2,3,4 = 8'b0000_1000, all other rows 0; generation=1.
  - Second step restores the original board; generation=2.
- Block still life: rows 1,2=8'b0000_0110; step.
  - board_out unchanged.
  - At scan (x=1, y=1): neigh_out=8'b0001_1100, cell_state=1.
- Wrap: load row0=8'b1000_0001 and row7=8'b1000_0001 (2x2 block split across all four edges); step.
  - Board unchanged.
  - Scan at (0,0): neigh_out=8'b1100_0001 (N=(0,7), W=(7,0), NW=(7,7)).
- Busy protection: pulse step and load_en (row0=8'hFF) mid-SCAN.
  - No restart, done still at cycle 65, row0 not written.
- Simultaneous load+step in IDLE: load applied, busy stays 0, no done.
- Reset mid-SCAN (cycle 20): drop rst_n asynchronously.
  - All outputs 0 immediately; board_out=0; generation=0; state IDLE after release.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: neighbour bit positions, scanner states and the life rule.
package gol_pkg;

    localparam int unsigned NB_N  = 0;
    localparam int unsigned NB_NE = 1;
    localparam int unsigned NB_E  = 2;
    localparam int unsigned NB_SE = 3;
    localparam int unsigned NB_S  = 4;
    localparam int unsigned NB_SW = 5;
    localparam int unsigned NB_W  = 6;
    localparam int unsigned NB_NW = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_e;

    function automatic logic gol_next(input logic alive, input logic [7:0] neigh);
        logic [3:0] count;
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + 4'(neigh[i]);
        end
        return (count == 4'd3) || (alive && (count == 4'd2));
    endfunction

endpackage

// File: rtl/gol_board_scanner_if.sv
// Host/neighbour-side bundle of the board scanner; slave is the scanner, master is the host.
interface gol_board_scanner_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    parameter int unsigned GEN_W  = 16
);
    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);

    logic                      load_en;
    logic [YW-1:0]             load_row;
    logic [WIDTH-1:0]          load_data;
    logic                      step;
    logic                      busy;
    logic                      done;
    logic                      neigh_valid;
    logic [7:0]                neigh_out;
    logic                      cell_state;
    logic [XW-1:0]             cell_x;
    logic [YW-1:0]             cell_y;
    logic [WIDTH*HEIGHT-1:0]   board_out;
    logic [GEN_W-1:0]          generation;

    modport master (
        output load_en, load_row, load_data, step,
        input  busy, done, neigh_valid, neigh_out, cell_state, cell_x, cell_y,
        input  board_out, generation
    );

    modport slave (
        input  load_en, load_row, load_data, step,
        output busy, done, neigh_valid, neigh_out, cell_state, cell_x, cell_y,
        output board_out, generation
    );

endinterface

// File: rtl/gol_neighbour_mux.sv
// Picks the eight toroidally-wrapped neighbours and the centre cell of (x, y) from a flat board.
module gol_neighbour_mux
    import gol_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    localparam int unsigned XW = $clog2(WIDTH),
    localparam int unsigned YW = $clog2(HEIGHT),
    localparam int unsigned IW = $clog2(WIDTH * HEIGHT)
) (
    input  logic [WIDTH*HEIGHT-1:0] board_i,
    input  logic [XW-1:0]           x_i,
    input  logic [YW-1:0]           y_i,
    output logic [7:0]              neigh_o,
    output logic                    alive_o
);

    int unsigned xc, yc, xm, xp, ym, yp;

    function automatic logic [IW-1:0] cell_idx(input int unsigned cx, input int unsigned cy);
        return IW'(cy * WIDTH + cx);
    endfunction

    always_comb begin
        xc = 32'(x_i);
        yc = 32'(y_i);
        xm = (xc == 0) ? WIDTH - 1 : xc - 1;
        xp = (xc == WIDTH - 1) ? 0 : xc + 1;
        ym = (yc == 0) ? HEIGHT - 1 : yc - 1;
        yp = (yc == HEIGHT - 1) ? 0 : yc + 1;

        neigh_o        = '0;
        neigh_o[NB_N]  = board_i[cell_idx(xc, ym)];
        neigh_o[NB_NE] = board_i[cell_idx(xp, ym)];
        neigh_o[NB_E]  = board_i[cell_idx(xp, yc)];
        neigh_o[NB_SE] = board_i[cell_idx(xp, yp)];
        neigh_o[NB_S]  = board_i[cell_idx(xc, yp)];
        neigh_o[NB_SW] = board_i[cell_idx(xm, yp)];
        neigh_o[NB_W]  = board_i[cell_idx(xm, yc)];
        neigh_o[NB_NW] = board_i[cell_idx(xm, ym)];
        alive_o        = board_i[cell_idx(xc, yc)];
    end

endmodule

// File: rtl/gol_board_scanner.sv
// Toroidal Game-of-Life board: host loads rows, each step scans one cell per clock into a
// shadow board which is committed at the end of the scan.
module gol_board_scanner
    import gol_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    parameter int unsigned GEN_W  = 16,
    localparam int unsigned XW = $clog2(WIDTH),
    localparam int unsigned YW = $clog2(HEIGHT),
    localparam int unsigned IW = $clog2(WIDTH * HEIGHT)
) (
    input logic                 clk,
    input logic                 rst_n,
    gol_board_scanner_if.slave  bus
);

    state_e                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [WIDTH*HEIGHT-1:0] board_q, board_d;
    logic [WIDTH*HEIGHT-1:0] shadow_q, shadow_d;
    logic [GEN_W-1:0]        gen_q, gen_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;

    logic [7:0]    neigh;
    logic          alive;
    logic [IW-1:0] cur_idx;

    // Neighbours always come from the committed board so a scan never sees its own writes.
    gol_neighbour_mux #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_neighbour_mux (
        .board_i (board_q),
        .x_i     (x_q),
        .y_i     (y_q),
        .neigh_o (neigh),
        .alive_o (alive)
    );

    assign cur_idx = IW'(32'(y_q) * WIDTH + 32'(x_q));

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        board_d  = board_q;
        shadow_d = shadow_q;
        gen_d    = gen_q;

        unique case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    // Rows outside the board match no iteration and are dropped.
                    for (int r = 0; r < int'(HEIGHT); r++) begin
                        if (32'(bus.load_row) == r) begin
                            board_d[r*WIDTH +: WIDTH] = bus.load_data;
                        end
                    end
                end else if (bus.step) begin
                    state_d = SCAN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            SCAN: begin
                shadow_d[cur_idx] = gol_next(alive, neigh);
                if (x_q == XW'(WIDTH - 1)) begin
                    x_d = '0;
                    if (y_q == YW'(HEIGHT - 1)) begin
                        y_d     = '0;
                        state_d = COMMIT;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            COMMIT: begin
                board_d = shadow_q;
                gen_d   = gen_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == COMMIT);
        valid_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            board_q  <= '0;
            shadow_q <= '0;
            gen_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            board_q  <= board_d;
            shadow_q <= shadow_d;
            gen_q    <= gen_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.neigh_valid = valid_q;
    assign bus.neigh_out   = valid_q ? neigh : 8'h00;
    assign bus.cell_state  = valid_q & alive;
    assign bus.cell_x      = x_q;
    assign bus.cell_y      = y_q;
    assign bus.board_out   = board_q;
    assign bus.generation  = gen_q;

endmodule

// File: tb/tb_gol_board_scanner.sv
// Scoreboard bench for gol_board_scanner on an 8x8 board: expected scan tuples and boards are
// queued from a reference life model when a step is issued and popped as the DUT produces them.
module tb_gol_board_scanner;

    localparam int W = 8;
    localparam int H = 8;

    typedef struct {
        logic [7:0] n;
        logic       s;
        logic [2:0] x;
        logic [2:0] y;
    } scan_t;

    logic clk;
    logic rst_n;

    gol_board_scanner_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(16)) bus ();

    gol_board_scanner #(
        .WIDTH  (W),
        .HEIGHT (H),
        .GEN_W  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] mboard;
    int          mgen;
    scan_t       scan_q[$];
    logic [63:0] board_q[$];
    int          gen_q[$];

    function automatic logic [7:0] m_neigh(input logic [63:0] b, input int x, input int y);
        int xm = (x + W - 1) % W;
        int xp = (x + 1) % W;
        int ym = (y + H - 1) % H;
        int yp = (y + 1) % H;
        logic [7:0] n;
        n[0] = b[ym*W + x];
        n[1] = b[ym*W + xp];
        n[2] = b[y*W + xp];
        n[3] = b[yp*W + xp];
        n[4] = b[yp*W + x];
        n[5] = b[yp*W + xm];
        n[6] = b[y*W + xm];
        n[7] = b[ym*W + xm];
        return n;
    endfunction

    task automatic load_board(input logic [63:0] b);
        for (int r = 0; r < H; r++) begin
            @(negedge clk);
            bus.load_en   = 1'b1;
            bus.load_row  = 3'(r);
            bus.load_data = b[r*W +: W];
        end
        @(negedge clk);
        bus.load_en = 1'b0;
        mboard = b;
        vectors++;
        if (bus.board_out !== b) begin
            miscompares++;
            $display("FAIL load_board: board_out=%h expected=%h", bus.board_out, b);
        end
    endtask

    // Issues one step and follows it to completion, optionally poking step/load mid-scan.
    task automatic run_step(input bit inject, input bit spot_en, input int sx, input int sy,
                            input logic [7:0] sn, input logic ss);
        scan_t       e;
        logic [63:0] nb;
        logic [63:0] eb;
        int          eg;
        int          c;
        int          cyc;
        bit          seen;

        nb = mboard;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.n = m_neigh(mboard, x, y);
                e.s = mboard[y*W + x];
                e.x = 3'(x);
                e.y = 3'(y);
                scan_q.push_back(e);
                c = $countones(e.n);
                nb[y*W + x] = e.s ? (c == 2 || c == 3) : (c == 3);
            end
        end
        board_q.push_back(nb);
        gen_q.push_back(mgen + 1);

        @(negedge clk);
        bus.step = 1'b1;
        @(posedge clk);
        #1;
        bus.step = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc <= 200) begin
            if (cyc == 1) begin
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_in_scan: busy=%b expected=1", bus.busy);
                end
            end
            if (inject && cyc == 20) begin
                bus.step      = 1'b1;
                bus.load_en   = 1'b1;
                bus.load_row  = 3'd0;
                bus.load_data = 8'hFF;
            end else if (inject && cyc == 21) begin
                bus.step    = 1'b0;
                bus.load_en = 1'b0;
            end
            if (bus.neigh_valid) begin
                vectors++;
                if (scan_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scan_extra: cycle %0d x=%0d y=%0d with no expected cell",
                             cyc, bus.cell_x, bus.cell_y);
                end else begin
                    e = scan_q.pop_front();
                    if ({bus.neigh_out, bus.cell_state, bus.cell_x, bus.cell_y} !==
                        {e.n, e.s, e.x, e.y}) begin
                        miscompares++;
                        $display("FAIL scan_cell: got n=%b s=%b x=%0d y=%0d expected n=%b s=%b x=%0d y=%0d",
                                 bus.neigh_out, bus.cell_state, bus.cell_x, bus.cell_y,
                                 e.n, e.s, e.x, e.y);
                    end
                end
                if (spot_en && int'(bus.cell_x) == sx && int'(bus.cell_y) == sy) begin
                    vectors++;
                    if ({bus.neigh_out, bus.cell_state} !== {sn, ss}) begin
                        miscompares++;
                        $display("FAIL spot_cell(%0d,%0d): n=%b s=%b expected n=%b s=%b",
                                 sx, sy, bus.neigh_out, bus.cell_state, sn, ss);
                    end
                end
            end
            if (bus.done) begin
                seen = 1'b1;
                vectors++;
                if (cyc != 65 || bus.neigh_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_latency: done at cycle %0d valid=%b expected cycle 65 valid=0",
                             cyc, bus.neigh_valid);
                end
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles, expected at 65", cyc - 1);
            bus.step    = 1'b0;
            bus.load_en = 1'b0;
        end

        @(posedge clk);
        #1;
        eb = board_q.pop_front();
        eg = gen_q.pop_front();
        mboard = eb;
        mgen   = eg;
        vectors++;
        if (bus.board_out !== eb) begin
            miscompares++;
            $display("FAIL next_board: board_out=%h expected=%h", bus.board_out, eb);
        end
        vectors++;
        if (bus.generation !== 16'(eg)) begin
            miscompares++;
            $display("FAIL generation: generation=%0d expected=%0d", bus.generation, eg);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || scan_q.size() != 0) begin
            miscompares++;
            $display("FAIL back_to_idle: busy=%b done=%b cells_missing=%0d expected 0 0 0",
                     bus.busy, bus.done, scan_q.size());
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({bus.busy, bus.done, bus.neigh_valid, bus.neigh_out, bus.cell_state,
             bus.cell_x, bus.cell_y} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b valid=%b n=%h s=%b x=%0d y=%0d expected all 0",
                     bus.busy, bus.done, bus.neigh_valid, bus.neigh_out, bus.cell_state,
                     bus.cell_x, bus.cell_y);
        end
        vectors++;
        if (bus.board_out !== 64'h0 || bus.generation !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: board=%h gen=%0d expected 0 0", bus.board_out,
                     bus.generation);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_blinker();
        load_board(64'h0000_0000_1C00_0000);
        run_step(1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
        vectors++;
        if (bus.board_out !== 64'h0000_0008_0808_0000) begin
            miscompares++;
            $display("FAIL blinker_vertical: board=%h expected=%h", bus.board_out,
                     64'h0000_0008_0808_0000);
        end
        run_step(1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
        vectors++;
        if (bus.board_out !== 64'h0000_0000_1C00_0000 || bus.generation !== 16'd2) begin
            miscompares++;
            $display("FAIL blinker_restore: board=%h gen=%0d expected=%h 2", bus.board_out,
                     bus.generation, 64'h0000_0000_1C00_0000);
        end
    endtask

    task automatic test_block();
        load_board(64'h0000_0000_0006_0600);
        run_step(1'b0, 1'b1, 1, 1, 8'b0001_1100, 1'b1);
        vectors++;
        if (bus.board_out !== 64'h0000_0000_0006_0600) begin
            miscompares++;
            $display("FAIL block_still: board=%h expected=%h", bus.board_out,
                     64'h0000_0000_0006_0600);
        end
    endtask

    task automatic test_wrap();
        load_board(64'h8100_0000_0000_0081);
        run_step(1'b0, 1'b1, 0, 0, 8'b1100_0001, 1'b1);
        vectors++;
        if (bus.board_out !== 64'h8100_0000_0000_0081) begin
            miscompares++;
            $display("FAIL wrap_still: board=%h expected=%h", bus.board_out,
                     64'h8100_0000_0000_0081);
        end
    endtask

    task automatic test_busy_protect();
        // Row 0 holds 8'h81 here, so a leaked load of 8'hFF would change the result.
        run_step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
        vectors++;
        if (bus.board_out[7:0] !== 8'h81) begin
            miscompares++;
            $display("FAIL busy_load_ignored: row0=%h expected=81", bus.board_out[7:0]);
        end
    endtask

    task automatic test_load_and_step();
        bit saw;
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.step      = 1'b1;
        bus.load_row  = 3'd5;
        bus.load_data = 8'hA5;
        @(negedge clk);
        bus.load_en = 1'b0;
        bus.step    = 1'b0;
        mboard[5*W +: W] = 8'hA5;
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.done || bus.neigh_valid) saw = 1'b1;
        end
        vectors++;
        if (saw !== 1'b0) begin
            miscompares++;
            $display("FAIL load_step_no_scan: busy/done/valid seen=%b expected=0", saw);
        end
        vectors++;
        if (bus.board_out !== mboard) begin
            miscompares++;
            $display("FAIL load_step_applied: board=%h expected=%h", bus.board_out, mboard);
        end
    endtask

    task automatic test_reset_mid_scan();
        load_board(64'h0000_0000_1C00_0000);
        @(negedge clk);
        bus.step = 1'b1;
        @(posedge clk);
        #1;
        bus.step = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.neigh_valid, bus.neigh_out, bus.cell_state,
             bus.cell_x, bus.cell_y} !== 16'h0000) begin
            miscompares++;
            $display("FAIL abort_outputs: busy=%b done=%b valid=%b n=%h s=%b x=%0d y=%0d expected all 0",
                     bus.busy, bus.done, bus.neigh_valid, bus.neigh_out, bus.cell_state,
                     bus.cell_x, bus.cell_y);
        end
        vectors++;
        if (bus.board_out !== 64'h0 || bus.generation !== 16'h0) begin
            miscompares++;
            $display("FAIL abort_board: board=%h gen=%0d expected 0 0", bus.board_out,
                     bus.generation);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mboard = '0;
        mgen   = 0;
        scan_q.delete();
        board_q.delete();
        gen_q.delete();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.neigh_valid !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: busy=%b valid=%b done=%b expected 0 0 0", bus.busy,
                     bus.neigh_valid, bus.done);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_row  = '0;
        bus.load_data = '0;
        bus.step      = 1'b0;
        mboard        = '0;
        mgen          = 0;

        test_reset();
        test_blinker();
        test_block();
        test_wrap();
        test_busy_protect();
        test_load_and_step();
        test_reset_mid_scan();
        test_blinker();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
